// File: rtl/regout_sched_pkg.sv
// Shared constants and state encoding for the reg_out strobe sequencer.
package regout_sched_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 3;
  localparam int NGRP_W = 8;
  localparam int GAP_W  = 4;

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GAP,
    DONE,
    FLUSH
  } state_t;

endpackage

// File: rtl/regout_gap_tmr.sv
// Loadable down-counter that paces the idle cycles between reg_out strobes.
module regout_gap_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  // Expiry at one lets the FSM return to ARM so exactly load_val idle cycles pass.
  assign expired = (count <= W'(1));

endmodule

// File: rtl/regout_sched.sv
// reg_out strobe sequencer for the input-buffer 8:1 mux path.
// Define REGOUT_SCHED_FLUSH_EN to flush a partial group on abort.
module regout_sched (
  input  logic                               SYS_CLK,
  input  logic                               SYS_NRST,
  input  logic                               start_i,
  input  logic [regout_sched_pkg::NGRP_W-1:0] num_grp_i,
  input  logic [regout_sched_pkg::GAP_W-1:0]  gap_i,
  input  logic                               abort_i,
  input  logic                               src_valid_i,
  input  logic                               dst_ready_i,
  output logic                               reg_out_o,
  output logic [regout_sched_pkg::LANE_W-1:0] lane_o,
  output logic                               grp_done_o,
  output logic [regout_sched_pkg::NGRP_W-1:0] grp_cnt_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               flush_o
);

  import regout_sched_pkg::*;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q;
  logic [NGRP_W-1:0]   grp_cnt_q;
  logic [NGRP_W-1:0]   num_grp_q;
  logic [GAP_W-1:0]    gap_q;
  logic [GAP_W-1:0]    tmr_count;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_expired;
  logic                go;
  logic                wrap;
  logic                last_grp;
  logic                latch;
  logic                strobe;
  logic                grp_done;
  logic                done;
  logic                flush;
  state_t              abort_dest;

  // dst_ready only gates the first lane of a group; src_valid gates every lane.
  assign go       = src_valid_i && (lane_q != '0 || dst_ready_i);
  assign wrap     = (lane_q == LANE_LAST);
  assign last_grp = ({1'b0, grp_cnt_q} + (NGRP_W+1)'(1)) == {1'b0, num_grp_q};

`ifdef REGOUT_SCHED_FLUSH_EN
  assign abort_dest = (lane_q != '0) ? FLUSH : IDLE;
`else
  assign abort_dest = IDLE;
`endif

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    strobe   = 1'b0;
    grp_done = 1'b0;
    done     = 1'b0;
    flush    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          latch   = 1'b1;
          state_d = (num_grp_i == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        if (abort_i) begin
          state_d = abort_dest;
        end else if (go) begin
          strobe   = 1'b1;
          grp_done = wrap;
          if (wrap && last_grp) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (abort_i) begin
          state_d = abort_dest;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expired) state_d = ARM;
        end
      end
      DONE: begin
        if (abort_i) begin
          state_d = abort_dest;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef REGOUT_SCHED_FLUSH_EN
      // Flush walks the external counter back to lane 0 without loading the matrix.
      FLUSH: begin
        strobe = 1'b1;
        flush  = 1'b1;
        if (wrap) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      grp_cnt_q <= '0;
      num_grp_q <= '0;
      gap_q     <= '0;
    end else begin
      state_q <= state_d;
      if (strobe) lane_q <= lane_q + LANE_W'(1);
      if (latch) begin
        num_grp_q <= num_grp_i;
        gap_q     <= gap_i;
        grp_cnt_q <= '0;
      end else if (grp_done) begin
        grp_cnt_q <= grp_cnt_q + NGRP_W'(1);
      end
    end
  end

  regout_gap_tmr #(
    .W(GAP_W)
  ) u_gap_tmr (
    .clk      (SYS_CLK),
    .rst_n    (SYS_NRST),
    .load     (tmr_load),
    .load_val (gap_q),
    .dec      (tmr_dec),
    .count    (tmr_count),
    .expired  (tmr_expired)
  );

  assign reg_out_o  = strobe;
  assign lane_o     = lane_q;
  assign grp_done_o = grp_done;
  assign grp_cnt_o  = grp_cnt_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done;
`ifdef REGOUT_SCHED_FLUSH_EN
  assign flush_o    = flush;
`else
  assign flush_o    = 1'b0;
`endif

endmodule

// File: doc/regout_sched.md
Name: regout_sched

Overview:
Sequencer for the input-buffer 8:1 output mux path. Generates the single-cycle reg_out strobes that step the mux-select counter, and mirrors that counter's lane index. Paces strobes with a programmable gap, gates each 8-lane group on downstream matrix readiness, and reports group and frame completion. Sits between the buffer fill logic / register interface and the mux control.

Parameters:
LANES, 8, lanes per group; power of 2; must match the mux-select counter.
LANE_W, 3, log2(LANES).
NGRP_W, 8, width of the group-count request.
GAP_W, 4, width of the inter-strobe gap setting.

Ports:
SYS_CLK  in  1  clock; all logic on rising edge.
SYS_NRST  in  1  asynchronous active-low reset.
start_i  in  1  frame start pulse; sampled only in IDLE.
num_grp_i  in  NGRP_W  groups per frame; latched on accepted start.
gap_i  in  GAP_W  idle cycles between strobes; latched on accepted start.
abort_i  in  1  terminate frame.
src_valid_i  in  1  buffer has the next lane word available.
dst_ready_i  in  1  matrix can accept a new group.
reg_out_o  out  1  strobe to the mux control; one cycle per lane.
lane_o  out  LANE_W  mirror of the mux-select counter.
grp_done_o  out  1  reg_out_o on lane LANES-1; the matrix load strobe.
grp_cnt_o  out  NGRP_W  groups completed in the current frame.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse at frame completion.
flush_o  out  1  high while flush strobes are issued; tied to 0 without the macro.

Behaviour:
- Reset: state IDLE, and all outputs, lane_o, grp_cnt_o, gap counter and latched config are 0.
- States: IDLE, ARM, GAP, DONE, plus FLUSH when the optional feature is compiled in.
- IDLE + start_i:
  - Latches num_grp_i and gap_i, and clears grp_cnt_o.
  - If num_grp_i == 0, goes to DONE; otherwise goes to ARM.
  - start_i in any other state is ignored.
- go = src_valid_i && (lane_o != 0 || dst_ready_i). dst_ready_i is checked only at a group boundary.
- ARM: reg_out_o = go && !abort_i, combinational from the registered state.
- On each strobe:
  - lane_o increments, wrapping LANES-1 -> 0.
  - On lane LANES-1, grp_done_o is high and grp_cnt_o increments the next cycle.
- Next state after a strobe:
  - Last strobe of the last group: DONE.
  - Else gap == 0: stay in ARM. This gives full-rate back-to-back strobes.
  - Else: GAP, with the gap counter loaded to gap.
- GAP:
  - Counter decrements each cycle; returns to ARM the cycle after it reaches 1.
  - Exactly gap idle cycles separate consecutive strobes.
  - Waiting in ARM for go adds cycles on top of the gap.
- DONE: done_o = 1 for one cycle, then IDLE. grp_cnt_o holds its value until the next start.
- Latency: start accepted at cycle t; earliest reg_out_o is at t+1.
- lane_o is never cleared by start_i; it tracks the external counter, which only SYS_NRST clears.
  - A frame starting with lane_o != 0 makes its first group partial.
  - That group still counts when it wraps.
- abort_i, in any state except IDLE:
  - Blocks a same-cycle strobe (abort has priority).
  - Next state is IDLE, or FLUSH when compiled in.
  - No done_o pulse.
- Asynchronous reset mid-frame returns every register to its reset value immediately.

Optional Feature:
REGOUT_SCHED_FLUSH_EN.
- Defined, abort with lane_o != 0:
  - Enters FLUSH, which strobes reg_out_o every cycle and ignores src_valid_i, dst_ready_i and gap.
  - Continues until lane_o wraps to 0, then goes to IDLE.
  - flush_o = 1 during FLUSH; grp_done_o is suppressed on the wrap strobe; grp_cnt_o is unchanged.
- Defined, abort with lane_o == 0: goes straight to IDLE.
- Undefined: the FLUSH state is absent, abort goes to IDLE with lane_o held, and flush_o = 0.

Decomposition:
- Package regout_sched_pkg holds:
  - the state enum (IDLE/ARM/GAP/DONE/FLUSH);
  - the default LANES, LANE_W, NGRP_W and GAP_W constants;
  - a LANE_LAST constant.
- One sub-module, regout_gap_tmr: load/decrement down-counter with an "expired" output, instantiated once.

Test Plan:
1. num_grp=2, gap=0, src_valid and dst_ready held 1 -> 16 back-to-back reg_out_o; grp_done_o on the 8th and 16th; done_o at cycle 18; grp_cnt_o=2.
2. num_grp=1, gap=3 -> strobes spaced 4 cycles apart (3 idle between); lane_o steps 0..7 then returns to 0.
3. dst_ready=0 at lane 0 for 5 cycles, then 1 -> no strobe while low; mid-group dst_ready drop (lane 3) does not stall; src_valid drop stalls at any lane.
4. num_grp=0 -> done_o one cycle after start, no reg_out_o; start while busy is ignored (grp_cnt_o unaffected).
5. abort at lane 5:
   - same-cycle strobe blocked;
   - with the macro: 3 flush strobes with flush_o=1, no grp_done_o, lane_o=0, then IDLE;
   - without the macro: IDLE with lane_o=5.
6. SYS_NRST asserted mid-GAP -> all outputs 0 immediately; after release a new start behaves as in scenario 1.
